nim_output: RTL and testbench

NIM output pulse generator: the transmit-side counterpart of the NIM input conditioner. Turns a trigger event from fabric logic (rising edge of `trig_in`, or a software fire strobe) into one programmable NIM pulse with a programmable delay, width, post-pulse holdoff and output polarity. Sits between the trigger/coincidence logic and the NIM output driver pins, one instance per output channel. Also counts emitted pulses and rejected triggers for register readback.

---
 rtl/nim_pkg.sv | 26 ++
 rtl/nim_down_counter.sv | 28 ++
 rtl/nim_output.sv | 171 +++++++++++++++++
 tb/tb_nim_output.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nim_pkg.sv
// Shared types and constants for the NIM output pulse generator.
package nim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } nim_out_state_t;

  // Rejected-fire counter sticks here instead of wrapping.
  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  // Previous-trigger register starts high so a level held through reset is not an edge.
  localparam logic TRIG_D_RESET = 1'b1;

  // Largest of three widths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/nim_down_counter.sv
// Loadable down counter shared by the delay, pulse and holdoff phases.
module nim_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; the count never goes below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nim_output.sv
// NIM output pulse generator: turns a trigger edge or software strobe into one
// delayed, programmable-width pulse followed by a holdoff, and counts pulses
// and rejected fires.
module nim_output
  import nim_pkg::*;
#(
  parameter int DELAY_W   = 16,
  parameter int WIDTH_W   = 16,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 invert,
  input  logic [DELAY_W-1:0]   delay,
  input  logic [WIDTH_W-1:0]   width,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 trig_in,
  input  logic                 sw_fire,
  output logic                 nim_out,
  output logic                 busy,
  output logic [31:0]          pulse_count,
  output logic [15:0]          dropped_count
);

  localparam int CNT_W = max3(DELAY_W, WIDTH_W, HOLDOFF_W);

  nim_out_state_t state, state_d;

  logic                 pulse_q, pulse_d;
  logic                 trig_d;
  logic                 fire;
  logic                 latch_settings;
  logic                 pulse_start;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 cnt_zero;
  logic [WIDTH_W-1:0]   width_m1_in;
  logic [WIDTH_W-1:0]   width_m1_q;
  logic [HOLDOFF_W-1:0] holdoff_q;

  // A width of zero behaves as a one-cycle pulse, so the counter load is max(width,1)-1.
  assign width_m1_in = (width == '0) ? '0 : (width - WIDTH_W'(1));

  assign fire    = enable & ((trig_in & ~trig_d) | sw_fire);
  assign nim_out = pulse_q ^ invert;
  assign busy    = (state != IDLE);

  nim_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic: walk delay -> pulse -> holdoff using the shared counter.
  always_comb begin
    state_d        = state;
    pulse_d        = pulse_q;
    latch_settings = 1'b0;
    pulse_start    = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_val   = '0;
    case (state)
      IDLE: begin
        if (fire) begin
          latch_settings = 1'b1;
          cnt_load       = 1'b1;
          if (delay == '0) begin
            state_d      = PULSE;
            pulse_d      = 1'b1;
            pulse_start  = 1'b1;
            cnt_load_val = CNT_W'(width_m1_in);
          end else begin
            state_d      = DELAY;
            cnt_load_val = CNT_W'(delay - DELAY_W'(1));
          end
        end
      end
      DELAY: begin
        if (cnt_zero) begin
          state_d      = PULSE;
          pulse_d      = 1'b1;
          pulse_start  = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(width_m1_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          pulse_d = 1'b0;
          if (holdoff_q != '0) begin
            state_d      = HOLDOFF;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(holdoff_q - HOLDOFF_W'(1));
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end
    endcase
  end

  // State and pulse output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_d;
      pulse_q <= pulse_d;
    end
  end

  // Previous trigger level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_d <= TRIG_D_RESET;
    end else begin
      trig_d <= trig_in;
    end
  end

  // Capture width and holdoff at the accepting edge so later changes do not disturb the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_m1_q <= '0;
      holdoff_q  <= '0;
    end else if (latch_settings) begin
      width_m1_q <= width_m1_in;
      holdoff_q  <= holdoff;
    end
  end

  // Readback counters: pulses wrap, rejected fires saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_count   <= '0;
      dropped_count <= '0;
    end else begin
      if (pulse_start) begin
        pulse_count <= pulse_count + 32'd1;
      end
      if (fire && (state != IDLE) && (dropped_count != DROP_SAT)) begin
        dropped_count <= dropped_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_nim_output.sv
// Self-checking bench for nim_output: table of single-shot sequences plus
// hand-written corner cases (reset, spacing, saturation, enable, mid-pulse reset).
module tb_nim_output;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        invert;
  logic [15:0] delay;
  logic [15:0] width;
  logic [15:0] holdoff;
  logic        trig_in;
  logic        sw_fire;
  logic        nim_out;
  logic        busy;
  logic [31:0] pulse_count;
  logic [15:0] dropped_count;

  int checks      = 0;
  int failures    = 0;
  int exp_pulses  = 0;
  int exp_dropped = 0;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [15:0] w;
    logic [15:0] h;
    logic        inv;
    logic        use_trig;
    logic        use_sw;
    int          rise;
    int          fall;
    int          idle;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  nim_output #(
    .DELAY_W   (16),
    .WIDTH_W   (16),
    .HOLDOFF_W (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .invert        (invert),
    .delay         (delay),
    .width         (width),
    .holdoff       (holdoff),
    .trig_in       (trig_in),
    .sw_fire       (sw_fire),
    .nim_out       (nim_out),
    .busy          (busy),
    .pulse_count   (pulse_count),
    .dropped_count (dropped_count)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    delay   = v.d;
    width   = v.w;
    holdoff = v.h;
    invert  = v.inv;
    trig_in = v.use_trig;
    sw_fire = v.use_sw;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " pulse_count"}, pulse_count, 32'(exp_pulses));
    checkOutput({tag, " dropped_count"}, {16'd0, dropped_count}, 32'(exp_dropped));
  endtask

  initial begin
    vec_t v;
    logic exp_hi;
    logic prev;
    int   starts[$];
    int   spacing;

    vecs[0] = '{"d3w5",      16'd3, 16'd5, 16'd0,  1'b0, 1'b1, 1'b0, 3, 8, 8};
    vecs[1] = '{"d0w0inv",   16'd0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b1, 0, 1, 1};
    vecs[2] = '{"d0w4h10",   16'd0, 16'd4, 16'd10, 1'b0, 1'b0, 1'b1, 0, 4, 14};
    vecs[3] = '{"d2w1h3inv", 16'd2, 16'd1, 16'd3,  1'b1, 1'b1, 1'b0, 2, 3, 6};
    vecs[4] = '{"trigsw",    16'd1, 16'd3, 16'd1,  1'b0, 1'b1, 1'b1, 1, 4, 5};

    // Reset with trigger held high, then release with it still high.
    reset   = 1'b1;
    enable  = 1'b1;
    invert  = 1'b0;
    trig_in = 1'b1;
    sw_fire = 1'b0;
    delay   = 16'd0;
    width   = 16'd0;
    holdoff = 16'd0;
    tick();
    tick();
    checkOutput("reset nim_out", {31'd0, nim_out}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkCounters("reset");
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("held trig busy", {31'd0, busy}, 32'd0);
    checkOutput("held trig nim_out", {31'd0, nim_out}, 32'd0);
    checkCounters("held trig");
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
    exp_pulses++;
    checkOutput("late edge nim_out", {31'd0, nim_out}, 32'd1);
    checkCounters("late edge");
    trig_in = 1'b0;
    tick();
    checkOutput("late edge end nim_out", {31'd0, nim_out}, 32'd0);
    checkOutput("late edge end busy", {31'd0, busy}, 32'd0);

    // Table of single-shot sequences; settings are scrambled right after the fire.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      applyStimulus(v);
      for (int e = 0; e <= v.idle + 1; e++) begin
        tick();
        if (e == 0) begin
          trig_in = 1'b0;
          sw_fire = 1'b0;
          delay   = 16'd7;
          width   = 16'd9;
          holdoff = 16'd2;
        end
        exp_hi = (e >= v.rise) && (e < v.fall);
        checkOutput($sformatf("%s nim_out e=%0d", v.name, e), {31'd0, nim_out}, {31'd0, exp_hi ^ v.inv});
        checkOutput($sformatf("%s busy e=%0d", v.name, e), {31'd0, busy}, {31'd0, (e < v.idle)});
        if (e == v.rise) begin
          exp_pulses++;
          checkOutput($sformatf("%s pulse_count e=%0d", v.name, e), pulse_count, 32'(exp_pulses));
        end
      end
      checkCounters(v.name);
    end

    // Fire every 3 cycles with width 4, holdoff 10: accepted at 0 and 15, others dropped.
    delay   = 16'd0;
    width   = 16'd4;
    holdoff = 16'd10;
    invert  = 1'b0;
    prev    = nim_out;
    for (int c = 0; c < 30; c++) begin
      sw_fire = ((c % 3) == 0);
      tick();
      if (nim_out && !prev) starts.push_back(c);
      prev = nim_out;
    end
    sw_fire = 1'b0;
    exp_pulses  += 2;
    exp_dropped += 8;
    checkOutput("spacing starts", 32'(starts.size()), 32'd2);
    spacing = (starts.size() >= 2) ? (starts[1] - starts[0]) : -1;
    checkOutput("spacing cycles", 32'(spacing), 32'd15);
    checkOutput("spacing busy end", {31'd0, busy}, 32'd0);
    checkCounters("spacing");

    // Enable dropped during DELAY: pulse still emits, disabled fires are ignored.
    delay   = 16'd4;
    width   = 16'd2;
    holdoff = 16'd0;
    sw_fire = 1'b1;
    tick();
    sw_fire = 1'b0;
    tick();
    enable  = 1'b0;
    sw_fire = 1'b1;
    tick();
    sw_fire = 1'b0;
    tick();
    checkOutput("enable e3 nim_out", {31'd0, nim_out}, 32'd0);
    tick();
    exp_pulses++;
    checkOutput("enable e4 nim_out", {31'd0, nim_out}, 32'd1);
    checkCounters("enable e4");
    tick();
    checkOutput("enable e5 nim_out", {31'd0, nim_out}, 32'd1);
    tick();
    checkOutput("enable e6 nim_out", {31'd0, nim_out}, 32'd0);
    checkOutput("enable e6 busy", {31'd0, busy}, 32'd0);
    trig_in = 1'b1;
    sw_fire = 1'b1;
    tick();
    trig_in = 1'b0;
    sw_fire = 1'b0;
    tick();
    checkOutput("disabled fire busy", {31'd0, busy}, 32'd0);
    checkCounters("disabled fire");
    enable = 1'b1;

    // Dropped-fire saturation: one long sequence with sw_fire held every cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pulses  = 0;
    exp_dropped = 0;
    delay   = 16'd0;
    width   = 16'hFFFF;
    holdoff = 16'hFFFF;
    sw_fire = 1'b1;
    tick();
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 65534) begin
        checkOutput("sat pre dropped_count", {16'd0, dropped_count}, 32'd65534);
      end
    end
    sw_fire = 1'b0;
    checkOutput("sat dropped_count", {16'd0, dropped_count}, 32'h0000FFFF);
    checkOutput("sat pulse_count", pulse_count, 32'd1);

    // Reset in the middle of a pulse with inverted output, then a normal fire.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    invert  = 1'b1;
    delay   = 16'd0;
    width   = 16'd10;
    holdoff = 16'd0;
    sw_fire = 1'b1;
    tick();
    sw_fire = 1'b0;
    tick();
    tick();
    checkOutput("midpulse nim_out", {31'd0, nim_out}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pulses  = 0;
    exp_dropped = 0;
    checkOutput("midreset nim_out", {31'd0, nim_out}, 32'd1);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkCounters("midreset");
    delay   = 16'd1;
    width   = 16'd2;
    sw_fire = 1'b1;
    tick();
    sw_fire = 1'b0;
    checkOutput("refire e0 nim_out", {31'd0, nim_out}, 32'd1);
    checkOutput("refire e0 busy", {31'd0, busy}, 32'd1);
    tick();
    exp_pulses++;
    checkOutput("refire e1 nim_out", {31'd0, nim_out}, 32'd0);
    tick();
    checkOutput("refire e2 nim_out", {31'd0, nim_out}, 32'd0);
    tick();
    checkOutput("refire e3 nim_out", {31'd0, nim_out}, 32'd1);
    checkOutput("refire e3 busy", {31'd0, busy}, 32'd0);
    checkCounters("refire");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
